// File: rtl/evg_pkg.sv
// Shared event codes, transmit-word lane positions and source select for the EVG transmitter.
package evg_pkg;
  localparam logic [7:0] EVCODE_SHIFT0       = 8'h70;
  localparam logic [7:0] EVCODE_SHIFT1       = 8'h71;
  localparam logic [7:0] EVCODE_LOAD_SECONDS = 8'h7D;
  localparam logic [7:0] EVCODE_NULL         = 8'h00;
  localparam logic [7:0] K28_5               = 8'hBC;

  localparam int TX_EVENT_LSB = 0;
  localparam int TX_EVENT_MSB = 7;
  localparam int TX_DBUS_LSB  = 8;
  localparam int TX_DBUS_MSB  = 15;

  localparam int SECONDS_W = 32;

  typedef enum logic [2:0] {
    SRC_IDLE,
    SRC_PPS,
    SRC_COMMA,
    SRC_USER,
    SRC_SHIFT
  } evSrc_t;

  // Codes the link reserves for itself; a user may not inject them.
  function automatic logic isReservedCode(input logic [7:0] code);
    return (code == EVCODE_SHIFT0) || (code == EVCODE_SHIFT1) ||
           (code == EVCODE_LOAD_SECONDS) || (code == K28_5);
  endfunction
endpackage

// File: rtl/evg_tx_small_if.sv
// User event-code handshake: requester holds eventCode with eventValid until eventReady.
interface evg_tx_small_if;
  logic       eventValid;
  logic [7:0] eventCode;
  logic       eventReady;

  modport master (output eventValid, output eventCode, input eventReady);
  modport slave  (input eventValid, input eventCode, output eventReady);
endinterface

// File: rtl/evg_seconds_shifter.sv
// Seconds counter plus MSB-first shift of the next seconds value, paced by a spacing counter.
// Requests one bit at a time; a blocked request simply waits for shiftGrant.
module evg_seconds_shifter
  import evg_pkg::*;
#(
  parameter int SHIFT_INTERVAL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 setSecondsStrobe,
  input  logic [SECONDS_W-1:0] setSecondsValue,
  input  logic                 shiftGrant,
  input  logic                 loadGrant,
  output logic                 shiftRequest,
  output logic                 shiftBit,
  output logic [SECONDS_W-1:0] seconds,
  output logic                 shiftOverrun
);
  localparam logic [15:0] SPACING = 16'(SHIFT_INTERVAL);

  logic [SECONDS_W-1:0] shiftReg;
  logic [SECONDS_W-1:0] secondsInc;
  logic [5:0]           bitCnt;
  logic [15:0]          spaceCnt;

  assign secondsInc   = seconds + 32'd1;
  assign shiftRequest = (bitCnt != 6'd0) && (spaceCnt >= SPACING);
  assign shiftBit     = shiftReg[SECONDS_W-1];

  // spaceCnt restarts at 1 so that it equals the cycles elapsed since the last shift/reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seconds      <= '0;
      shiftReg     <= '0;
      bitCnt       <= 6'd0;
      spaceCnt     <= 16'd0;
      shiftOverrun <= 1'b0;
    end else begin
      shiftOverrun <= loadGrant && (bitCnt != 6'd0);
      if (setSecondsStrobe) begin
        seconds  <= setSecondsValue;
        shiftReg <= setSecondsValue;
        bitCnt   <= 6'd32;
        spaceCnt <= 16'd1;
      end else if (loadGrant) begin
        seconds  <= secondsInc;
        shiftReg <= secondsInc;
        bitCnt   <= 6'd32;
        spaceCnt <= 16'd1;
      end else if (shiftGrant) begin
        shiftReg <= {shiftReg[SECONDS_W-2:0], 1'b0};
        bitCnt   <= bitCnt - 6'd1;
        spaceCnt <= 16'd1;
      end else if (spaceCnt < SPACING) begin
        spaceCnt <= spaceCnt + 16'd1;
      end
    end
  end
endmodule

// File: rtl/evg_tx_small.sv
// MRF-style EVG transmit word builder: PPS load > forced comma > user event > seconds shift > idle comma.
// One cycle from arbitration to evgTxWord; eventReady is combinational and drops on PPS/comma cycles.
module evg_tx_small
  import evg_pkg::*;
#(
  parameter int COMMA_INTERVAL = 64,
  parameter int SHIFT_INTERVAL = 16
) (
  input  logic                 evgTxClk,
  input  logic                 evgTxReset,
  input  logic                 ppsMarker,
  evg_tx_small_if.slave        userEvent,
  input  logic [7:0]           distributedDataBus,
  input  logic                 setSecondsStrobe,
  input  logic [SECONDS_W-1:0] setSecondsValue,
  output logic [SECONDS_W-1:0] seconds,
  output logic                 shiftOverrun,
  output logic                 reservedDrop,
  output logic [15:0]          evgTxWord,
  output logic [1:0]           evgCharIsK
);
  localparam logic [15:0] COMMA_LIMIT = 16'(COMMA_INTERVAL - 1);

  evSrc_t     src;
  logic [7:0] eventByte;
  logic [15:0] commaCnt;
  logic       ppsPrev;
  logic       ppsPending;
  logic       ppsEdge;
  logic       shiftRequest;
  logic       shiftBit;
  logic       loadGrant;
  logic       shiftGrant;

  assign ppsEdge    = ppsMarker && !ppsPrev;
  assign loadGrant  = (src == SRC_PPS);
  assign shiftGrant = (src == SRC_SHIFT);
  assign userEvent.eventReady = (src == SRC_USER) && !evgTxReset;

  // >= rather than == so a comma pre-empted by 0x7D goes out on the very next cycle.
  always_comb begin
    src = SRC_IDLE;
    if (ppsPending)                  src = SRC_PPS;
    else if (commaCnt >= COMMA_LIMIT) src = SRC_COMMA;
    else if (userEvent.eventValid)   src = SRC_USER;
    else if (shiftRequest)           src = SRC_SHIFT;
  end

  always_comb begin
    eventByte = K28_5;
    case (src)
      SRC_PPS:   eventByte = EVCODE_LOAD_SECONDS;
      SRC_USER:  eventByte = isReservedCode(userEvent.eventCode) ? EVCODE_NULL : userEvent.eventCode;
      SRC_SHIFT: eventByte = shiftBit ? EVCODE_SHIFT1 : EVCODE_SHIFT0;
      default:   eventByte = K28_5;
    endcase
  end

  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      evgTxWord    <= {8'h00, K28_5};
      evgCharIsK   <= 2'b01;
      reservedDrop <= 1'b0;
      commaCnt     <= 16'd0;
      ppsPrev      <= 1'b0;
      ppsPending   <= 1'b0;
    end else begin
      evgTxWord[TX_DBUS_MSB:TX_DBUS_LSB]   <= distributedDataBus;
      evgTxWord[TX_EVENT_MSB:TX_EVENT_LSB] <= eventByte;
      evgCharIsK   <= {1'b0, eventByte == K28_5};
      reservedDrop <= (src == SRC_USER) && isReservedCode(userEvent.eventCode);
      commaCnt     <= (eventByte == K28_5) ? 16'd0 : commaCnt + 16'd1;
      ppsPrev      <= ppsMarker;
      ppsPending   <= ppsEdge || (ppsPending && !loadGrant);
    end
  end

  evg_seconds_shifter #(
    .SHIFT_INTERVAL(SHIFT_INTERVAL)
  ) secondsShifter (
    .clk              (evgTxClk),
    .rst              (evgTxReset),
    .setSecondsStrobe (setSecondsStrobe),
    .setSecondsValue  (setSecondsValue),
    .shiftGrant       (shiftGrant),
    .loadGrant        (loadGrant),
    .shiftRequest     (shiftRequest),
    .shiftBit         (shiftBit),
    .seconds          (seconds),
    .shiftOverrun     (shiftOverrun)
  );
endmodule
